if_fetch_stage: RTL and testbench



---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_buf.sv | 63 ++++++
 rtl/if_fetch_stage.sv | 115 +++++++++++
 tb/tb_if_fetch_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_IDLE = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Force an address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry {pc, instr} FIFO between the memory response and IF/ID.
// Entry 0 is always the head, so the head outputs come straight from flops.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [31:0] push_pc_i,
  input  logic [31:0] push_instr_i,
  input  logic        pop_i,
  output logic [1:0]  count_o,
  output logic [31:0] head_pc_o,
  output logic [31:0] head_instr_o
);

  logic [31:0] pc_q    [2];
  logic [31:0] instr_q [2];
  logic [1:0]  count_q;
  logic        do_pop;
  logic        do_push;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  // Shift-register FIFO: pops move entry 1 down, pushes land behind the head.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count_q <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          pc_q[count_q[0]]    <= push_pc_i;
          instr_q[count_q[0]] <= push_instr_i;
          count_q             <= count_q + 2'd1;
        end
        2'b01: begin
          pc_q[0]    <= pc_q[1];
          instr_q[0] <= instr_q[1];
          count_q    <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            pc_q[0]    <= push_pc_i;
            instr_q[0] <= push_instr_i;
          end else begin
            pc_q[0]    <= pc_q[1];
            instr_q[0] <= instr_q[1];
            pc_q[1]    <= push_pc_i;
            instr_q[1] <= push_instr_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign count_o      = count_q;
  assign head_pc_o    = pc_q[0];
  assign head_instr_o = instr_q[0];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues one outstanding
// imem request at a time and buffers returned words for IF/ID.
//
//  state  | meaning
//  S_REQ  | request asserted at fetch_pc, waiting for gnt
//  S_WAIT | one request granted, waiting for rvalid
//  S_DROP | outstanding response is stale (redirect), discard it
//  S_IDLE | buffer full, no request until a pop frees an entry
module if_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o,
  output logic        flush_o
);

  localparam logic [1:0] FULL_CNT = 2'(BUF_DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q;
  logic [31:0]  req_pc_q;
  logic [1:0]   count;
  logic [1:0]   occ_after;
  logic [31:0]  head_pc;
  logic [31:0]  head_instr;
  logic         buf_valid;
  logic         gnt_acc;
  logic         pop;
  logic         push;
  logic         outstanding_after;

  assign buf_valid   = (count != 2'd0);
  assign imem_req_o  = (state_q == S_REQ) && !rst_i;
  assign imem_addr_o = fetch_pc_q;
  assign gnt_acc     = imem_req_o && imem_gnt_i;

  assign valid_o = buf_valid && !rst_i;
  assign instr_o = valid_o ? head_instr : NOP_INSTR;
  assign pc_o    = rst_i ? RESET_PC : (buf_valid ? head_pc : fetch_pc_q);
  assign flush_o = redirect_i && !rst_i;

  // Redirect wins over everything: no pop, no push, buffer cleared.
  assign pop  = valid_o && !stall_i && !redirect_i;
  assign push = (state_q == S_WAIT) && imem_rvalid_i && !redirect_i && !rst_i;

  // Only reached from S_WAIT where count <= 1, so this never wraps.
  assign occ_after = count + 2'd1 - {1'b0, pop};

  // A response still owed after this edge: new grant, or a wait that did not
  // complete now. An rvalid landing with the redirect retires the old request.
  assign outstanding_after = gnt_acc ||
                             (((state_q == S_WAIT) || (state_q == S_DROP)) && !imem_rvalid_i);

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    if (redirect_i) begin
      state_d = outstanding_after ? S_DROP : S_REQ;
    end else begin
      case (state_q)
        S_REQ:   if (gnt_acc) state_d = S_WAIT;
        S_WAIT:  if (imem_rvalid_i) state_d = (occ_after < FULL_CNT) ? S_REQ : S_IDLE;
        S_DROP:  if (imem_rvalid_i) state_d = S_REQ;
        S_IDLE:  if (pop) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_REQ;
    else       state_q <= state_d;
  end

  // Fetch PC advances on grant; req_pc remembers the address now in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
    end else begin
      if (redirect_i)   fetch_pc_q <= align_word(redirect_pc_i);
      else if (gnt_acc) fetch_pc_q <= fetch_pc_q + PC_STEP;
      if (gnt_acc)      req_pc_q   <= fetch_pc_q;
    end
  end

  fetch_buf u_buf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (redirect_i),
    .push_i       (push),
    .push_pc_i    (req_pc_q),
    .push_instr_i (imem_rdata_i),
    .pop_i        (pop),
    .count_o      (count),
    .head_pc_o    (head_pc),
    .head_instr_o (head_instr)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: behavioural imem plus a queue of expected
// {pc, instr} pairs consumed whenever IF/ID would accept an instruction.
module tb_if_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        valid_o;
  logic        flush_o;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .pc_o          (pc_o),
    .instr_o       (instr_o),
    .valid_o       (valid_o),
    .flush_o       (flush_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // stimulus controls applied at the start of each cycle
  logic        rst_v = 1'b1;
  logic        stall_v = 1'b0;
  logic        redir_v = 1'b0;
  logic [31:0] redir_pc_v = 32'h0;
  logic        gnt_en = 1'b1;
  int          rv_lat = 1;
  logic        hold_en = 1'b0;

  // memory model state
  logic        pend = 1'b0;
  int          pend_wait = 0;
  logic [31:0] pend_addr = 32'h0;

  logic [63:0] exp_q [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  // One clock cycle: drive inputs, answer imem, score any consumed instruction.
  task automatic step();
    logic [63:0] e;
    @(negedge clk_i);
    rst_i         = rst_v;
    stall_i       = stall_v;
    redirect_i    = redir_v;
    redirect_pc_i = redir_pc_v;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    if (pend) begin
      if (pend_wait <= 1) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(pend_addr);
        pend          = 1'b0;
      end else begin
        pend_wait--;
      end
    end
    #1;
    imem_gnt_i = imem_req_o && gnt_en;
    #1;
    if (imem_req_o && imem_gnt_i) begin
      pend      = 1'b1;
      pend_wait = rv_lat;
      pend_addr = imem_addr_o;
    end
    if (valid_o && !stall_i && !redirect_i && !rst_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {31'b0, valid_o}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("pop_pc", pc_o, e[63:32]);
        chk("pop_instr", instr_o, e[31:0]);
        if (hold_en && exp_q.size() == 0) stall_v = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    rst_v = 1'b1; redir_v = 1'b0; stall_v = 1'b0; hold_en = 1'b0; gnt_en = 1'b1;
    pend = 1'b0;
    exp_q.delete();
    step();
    step();
    rst_v = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      step();
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    int n = 0;
    step();
    while (!imem_req_o && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_req"}, {31'b0, imem_req_o}, 32'h1);
    chk({tag, "_addr"}, imem_addr_o, exp_addr);
  endtask

  initial begin
    // 1: reset outputs, then sequential fetch 0,4,8
    rv_lat = 1;
    rst_v = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_valid", {31'b0, valid_o}, 32'h0);
      chk("rst_instr", instr_o, 32'h0);
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_flush", {31'b0, flush_o}, 32'h0);
      chk("rst_req", {31'b0, imem_req_o}, 32'h0);
    end
    rst_v = 1'b0;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    hold_en = 1'b1;
    step();
    chk("t1_valid0", {31'b0, valid_o}, 32'h0);
    chk("t1_pc_empty", pc_o, 32'h0);
    chk("t1_req", {31'b0, imem_req_o}, 32'h1);
    chk("t1_addr", imem_addr_o, 32'h0);
    drain("t1_drain");

    // 2: six-cycle stall fills the buffer and stops requests
    do_reset();
    stall_v = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("t2_req_off", {31'b0, imem_req_o}, 32'h0);
    chk("t2_valid", {31'b0, valid_o}, 32'h1);
    chk("t2_head_pc", pc_o, 32'h0);
    push_exp(32'h0); push_exp(32'h4);
    stall_v = 1'b0; hold_en = 1'b1;
    step();
    chk("t2_idle_req", {31'b0, imem_req_o}, 32'h0);
    step();
    chk("t2_rereq", {31'b0, imem_req_o}, 32'h1);
    chk("t2_rereq_addr", imem_addr_o, 32'h8);
    chk("t2_drain", 32'(exp_q.size()), 32'd0);

    // 3: redirect while waiting; stale response discarded
    rv_lat = 3;
    do_reset();
    push_exp(32'h0);
    for (int i = 0; i < 5; i++) step();
    chk("t3_first", 32'(exp_q.size()), 32'd0);
    redir_v = 1'b1; redir_pc_v = 32'h100;
    step();
    chk("t3_flush", {31'b0, flush_o}, 32'h1);
    redir_v = 1'b0;
    push_exp(32'h100); push_exp(32'h104);
    hold_en = 1'b1;
    step();
    chk("t3_flush_off", {31'b0, flush_o}, 32'h0);
    chk("t3_valid", {31'b0, valid_o}, 32'h0);
    chk("t3_drop_req", {31'b0, imem_req_o}, 32'h0);
    chk("t3_pc_empty", pc_o, 32'h100);
    drain("t3_drain");

    // 4: redirect and stall together with two entries buffered
    rv_lat = 1;
    do_reset();
    stall_v = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("t4_full", {31'b0, valid_o}, 32'h1);
    redir_v = 1'b1; redir_pc_v = 32'h100;
    step();
    chk("t4_flush", {31'b0, flush_o}, 32'h1);
    redir_v = 1'b0;
    step();
    chk("t4_valid", {31'b0, valid_o}, 32'h0);
    chk("t4_req", {31'b0, imem_req_o}, 32'h1);
    chk("t4_addr", imem_addr_o, 32'h100);
    push_exp(32'h100); push_exp(32'h104);
    stall_v = 1'b0; hold_en = 1'b1;
    drain("t4_drain");

    // 5: misaligned redirect near the top of memory wraps to 0
    hold_en = 1'b0; stall_v = 1'b1;
    redir_v = 1'b1; redir_pc_v = 32'hFFFF_FFFE;
    step();
    redir_v = 1'b0;
    wait_req("t5_top", 32'hFFFF_FFFC);
    wait_req("t5_wrap", 32'h0000_0000);
    push_exp(32'hFFFF_FFFC); push_exp(32'h0); push_exp(32'h4);
    stall_v = 1'b0; hold_en = 1'b1;
    drain("t5_drain");

    // 6: reset mid-wait (redirect ignored under reset), stray rvalid after
    rv_lat = 3;
    do_reset();
    step();
    step();
    rst_v = 1'b1; redir_v = 1'b1; redir_pc_v = 32'h200;
    step();
    chk("t6_rst_flush", {31'b0, flush_o}, 32'h0);
    chk("t6_rst_req", {31'b0, imem_req_o}, 32'h0);
    rst_v = 1'b0; redir_v = 1'b0; gnt_en = 1'b0;
    step();
    chk("t6_stray_seen", {31'b0, imem_rvalid_i}, 32'h1);
    chk("t6_pc", pc_o, 32'h0);
    chk("t6_addr", imem_addr_o, 32'h0);
    step();
    chk("t6_valid", {31'b0, valid_o}, 32'h0);
    chk("t6_req", {31'b0, imem_req_o}, 32'h1);
    gnt_en = 1'b1; rv_lat = 1;
    push_exp(32'h0); push_exp(32'h4);
    hold_en = 1'b1;
    drain("t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
